bit_clock_recovery: RTL and testbench

Parametrised successor to the single-channel bit-clock recovery front end. Estimates the bit period of an asynchronous NRZ input by shortest-interval tracking with slow upward relaxation, and regenerates a phase-aligned recovered clock. Adds a lock state machine with loss-of-signal timeout, a mid-bit data sampler, and a pulse-driven phase-invert control. Sits between the serial input pin and the downstream bit deserialiser, clocked by the 200 MHz oversampling clock.

---
 rtl/bit_clock_recovery.sv | 147 ++++++++++++++
 tb/tb_bit_clock_recovery.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_clock_recovery.sv
// bit_clock_recovery: bit-period estimator and recovered-clock generator for an
// asynchronous NRZ input, with lock tracking, loss-of-signal timeout, mid-bit
// sampler and a pulse-driven half-period phase invert.
// Optional feature macro: BCR_GLITCH_FILTER_EN -- when defined, edges arriving
// less than MIN_PERIOD cycles after the last accepted edge are ignored.
module bit_clock_recovery #(
  parameter int PERIOD_W        = 16,
  parameter int PERIOD_INIT     = 801,
  parameter int RELAX_EDGES     = 16,
  parameter int LOCK_EDGES      = 32,
  parameter int PHASE_WIN_SHIFT = 3,
  parameter int MIN_PERIOD      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                signal_in,
  input  logic                invert,
  output logic                clk_rec,
  output logic                bit_valid,
  output logic                bit_data,
  output logic [PERIOD_W-1:0] period,
  output logic                locked,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {IDLE = 2'b00, TRACK = 2'b01, LOCKED = 2'b10} state_t;

  localparam logic [PERIOD_W-1:0] PERIOD_RST = PERIOD_W'(PERIOD_INIT);
  localparam logic [PERIOD_W-1:0] MIN_P      = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] ONE        = PERIOD_W'(1);
  localparam logic [8:0]          RELAX_N    = 9'(RELAX_EDGES);
  localparam logic [8:0]          LOCK_N     = 9'(LOCK_EDGES);

  state_t              fsm_state, fsm_next;
  logic                sync_p0, sync_p1, prev_p2;
  logic [PERIOD_W-1:0] cnt, ph, half, win;
  logic [8:0]          stable_cnt, lock_cnt, lock_inc;
  logic                edge_det, edge_acc, short_ivl, tracking;
  logic                good_edge, timeout, sched, pull_in, toggle, fall;

  // Edge qualification, interval classification and phase-generator decisions
  always_comb begin
    edge_det  = sync_p1 ^ prev_p2;
    short_ivl = (cnt < MIN_P);
    tracking  = (fsm_state != IDLE);
`ifdef BCR_GLITCH_FILTER_EN
    // The arming edge in IDLE is always taken; later short intervals are glitches.
    edge_acc  = edge_det && (!tracking || !short_ivl);
`else
    edge_acc  = edge_det;
`endif
    // interval >= period-1, evaluated without underflow
    good_edge = ({1'b0, cnt} + {{PERIOD_W{1'b0}}, 1'b1}) >= {1'b0, period};
    timeout   = tracking && ({3'b000, cnt} >= {period, 3'b000});
    lock_inc  = (lock_cnt == '1) ? lock_cnt : lock_cnt + 9'd1;
    half      = (period[PERIOD_W-1:1] == '0) ? ONE : (period >> 1);
    win       = period >> PHASE_WIN_SHIFT;
    sched     = (ph >= half - ONE);
    pull_in   = tracking && edge_acc && (ph < win);
    // An invert coinciding with a scheduled toggle cancels it
    toggle    = sched ^ invert;
    fall      = toggle && clk_rec;
  end

`ifndef BCR_GLITCH_FILTER_EN
  logic filter_unused;
  assign filter_unused = short_ivl;
`endif

  // Lock state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_state <= IDLE;
    else        fsm_state <= fsm_next;
  end

  // Lock next-state: arm on first edge, lock on a run of good edges, drop on bad edge or silence
  always_comb begin
    fsm_next = fsm_state;
    case (fsm_state)
      IDLE:    if (edge_acc) fsm_next = TRACK;
      TRACK:   if (timeout) fsm_next = IDLE;
               else if (edge_acc && good_edge && (lock_inc >= LOCK_N)) fsm_next = LOCKED;
      LOCKED:  if (timeout) fsm_next = IDLE;
               else if (edge_acc && !good_edge) fsm_next = TRACK;
      default: fsm_next = IDLE;
    endcase
  end

  // Input synchroniser and edge-reference register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= signal_in;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  // Interval counter, shortest-interval period tracking with slow upward relaxation, lock counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      period     <= PERIOD_RST;
      stable_cnt <= '0;
      lock_cnt   <= '0;
      locked     <= 1'b0;
    end else begin
      cnt    <= edge_acc ? ONE : ((cnt == '1) ? cnt : cnt + ONE);
      locked <= (fsm_next == LOCKED);
      if (timeout) begin
        lock_cnt <= '0;
      end else if (tracking && edge_acc) begin
        lock_cnt <= good_edge ? lock_inc : '0;
        if (cnt < period) begin
          period     <= cnt;
          stable_cnt <= '0;
        end else if ((stable_cnt + 9'd1) >= RELAX_N) begin
          period     <= (period == '1) ? period : period + ONE;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + 9'd1;
        end
      end
    end
  end

  // Recovered-clock phase counter, toggle, and mid-bit sampler on clk_rec falling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph        <= '0;
      clk_rec   <= 1'b0;
      bit_valid <= 1'b0;
      bit_data  <= 1'b0;
    end else begin
      ph        <= (invert || sched || pull_in) ? '0 : ph + ONE;
      clk_rec   <= clk_rec ^ toggle;
      bit_valid <= fall && !invert && locked;
      if (fall) bit_data <= sync_p1;
    end
  end

  assign state = fsm_state;

endmodule

// File: tb/tb_bit_clock_recovery.sv
// Testbench for bit_clock_recovery: directed NRZ streams checked every cycle
// against a behavioural model, plus hand-derived checkpoints.
// Honours BCR_GLITCH_FILTER_EN the same way as the design.
module tb_bit_clock_recovery;
  localparam int PW = 16;

`ifdef BCR_GLITCH_FILTER_EN
  localparam bit FILT  = 1'b1;
  localparam int GL_LO = 1;
`else
  localparam bit FILT  = 1'b0;
  localparam int GL_LO = 8;
`endif

  logic          clk = 1'b0;
  logic          rst_n, signal_in, invert;
  logic          clk_rec, bit_valid, bit_data, locked;
  logic [PW-1:0] period;
  logic [1:0]    state;

  int n_cmp = 0;
  int n_bad = 0;

  bit_clock_recovery dut (
    .clk(clk), .rst_n(rst_n), .signal_in(signal_in), .invert(invert),
    .clk_rec(clk_rec), .bit_valid(bit_valid), .bit_data(bit_data),
    .period(period), .locked(locked), .state(state)
  );

  always #5 clk = ~clk;

  // stream generator state
  int   bit_len = 20;
  int   bit_pos = 0;
  logic lvl = 1'b0;
  bit   run = 1'b1;
  bit   glitch_arm = 1'b0;

  // model state: input history, interval, period, relax/lock counts, lock state, clock phase
  int m_in [3];
  int m_cnt, m_per, m_stab, m_lock, m_st, m_ph, m_clk, m_vld, m_dat, m_lkd;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in = '{0, 0, 0};
    m_cnt = 0; m_per = 801; m_stab = 0; m_lock = 0; m_st = 0;
    m_ph = 0; m_clk = 0; m_vld = 0; m_dat = 0; m_lkd = 0;
  endtask

  task automatic model_step(input int sin, input int inv);
    int  interval, half_p, n_st, n_lock, n_per, n_stab;
    bit  edge_seen, acc, trk, expired, good, due, pull, flip;
    interval  = m_cnt;
    edge_seen = (m_in[1] != m_in[2]);
    trk       = (m_st != 0);
    acc       = edge_seen && (!FILT || !trk || interval >= 4);
    expired   = trk && (interval >= 8 * m_per);
    good      = (interval >= m_per - 1);
    half_p    = (m_per / 2 < 1) ? 1 : m_per / 2;
    due       = (m_ph >= half_p - 1);
    pull      = trk && acc && (m_ph < (m_per / 8));
    flip      = due ^ (inv != 0);
    // recovered clock and sampler
    m_vld = (flip && m_clk == 1 && inv == 0 && m_lkd == 1) ? 1 : 0;
    if (flip && m_clk == 1) m_dat = m_in[1];
    m_clk = flip ? 1 - m_clk : m_clk;
    m_ph  = (inv != 0 || due || pull) ? 0 : m_ph + 1;
    // period estimate and lock
    n_st = m_st; n_lock = m_lock; n_per = m_per; n_stab = m_stab;
    if (m_st == 0) begin
      if (acc) n_st = 1;
    end else if (expired) begin
      n_st = 0; n_lock = 0;
    end else if (acc) begin
      n_lock = good ? ((m_lock < 511) ? m_lock + 1 : 511) : 0;
      if (interval < m_per) begin
        n_per = interval; n_stab = 0;
      end else if (m_stab + 1 >= 16) begin
        n_per = (m_per < 65535) ? m_per + 1 : m_per; n_stab = 0;
      end else begin
        n_stab = m_stab + 1;
      end
      if (m_st == 1 && good && n_lock >= 32) n_st = 2;
      if (m_st == 2 && !good) n_st = 1;
    end
    m_st = n_st; m_lock = n_lock; m_per = n_per; m_stab = n_stab;
    m_lkd = (n_st == 2) ? 1 : 0;
    m_cnt = acc ? 1 : ((m_cnt < 65535) ? m_cnt + 1 : 65535);
    m_in[2] = m_in[1]; m_in[1] = m_in[0]; m_in[0] = sin;
  endtask

  // one clock: drive at negedge, advance model at posedge, compare at next negedge
  task automatic tick(input logic inv);
    logic drv;
    if (run && bit_pos >= bit_len) begin
      lvl = ~lvl;
      bit_pos = 0;
    end
    drv = lvl;
    if (glitch_arm && bit_pos >= GL_LO && bit_pos < GL_LO + 2) begin
      drv = ~lvl;
      if (bit_pos == GL_LO + 1) glitch_arm = 1'b0;
    end
    if (run) bit_pos++;
    signal_in = drv;
    invert    = inv;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(int'(drv), int'(inv));
    @(negedge clk);
    invert = 1'b0;
    chk("clk_rec",   clk_rec,   m_clk);
    chk("bit_valid", bit_valid, m_vld);
    chk("bit_data",  bit_data,  m_dat);
    chk("period",    period,    m_per);
    chk("locked",    locked,    m_lkd);
    chk("state",     state,     m_st);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  // length of one complete high phase of clk_rec; -1 if not seen in time
  task automatic high_run(output int len);
    int g;
    len = -1;
    g = 0;
    while (clk_rec !== 1'b0 && g < 100) begin tick(1'b0); g++; end
    while (clk_rec !== 1'b1 && g < 200) begin tick(1'b0); g++; end
    if (g < 200) begin
      len = 0;
      while (clk_rec === 1'b1 && len < 100) begin tick(1'b0); len++; end
    end
  endtask

  // cycles between two consecutive bit_valid strobes; -1 if not seen in time
  task automatic valid_gap(output int gap);
    int g;
    gap = -1;
    g = 0;
    while (bit_valid !== 1'b1 && g < 100) begin tick(1'b0); g++; end
    if (g < 100) begin
      gap = 0;
      do begin tick(1'b0); gap++; end while (bit_valid !== 1'b1 && gap < 100);
    end
  endtask

  initial begin
    int len, gap, cnt_v, half_m, prev_clk;
    rst_n = 1'b0; signal_in = 1'b0; invert = 1'b0;
    model_reset();
    @(negedge clk);

    // reset held with the input toggling
    bit_len = 3;
    ticks(8);
    chk("reset_clk_rec", clk_rec, 0);
    chk("reset_period", period, 801);
    chk("reset_locked", locked, 0);
    chk("reset_state", state, 0);
    chk("reset_bit_valid", bit_valid, 0);
    chk("reset_bit_data", bit_data, 0);

    // 20-cycle alternating bits from a clean start
    rst_n = 1'b1; lvl = 1'b0; bit_pos = 0; bit_len = 20;
    ticks(45);
    chk("period_after_2nd_edge", period, 20);
    chk("tracking_after_2nd_edge", state, 1);
    ticks(605);
    chk("not_locked_before_32_good", locked, 0);
    ticks(35);
    chk("locked_after_32_good", locked, 1);
    chk("locked_state", state, 2);
    chk("period_locked_20", period, 20);
    high_run(len);
    chk("clk_rec_high_len", len, 10);
    valid_gap(gap);
    chk("bit_valid_gap_20", gap, 20);

    // slower 24-cycle bits: relaxation climbs to 24/25 without losing lock
    bit_len = 24;
    ticks(2600);
    chk("period_24_25", (period == 24 || period == 25), 1);
    chk("locked_through_24", locked, 1);

    // back to 20: one bad edge then relock
    bit_len = 20;
    ticks(950);
    chk("relocked_at_20", locked, 1);

    // invert pulse away from a scheduled toggle: no strobe on the forced fall
    for (int i = 0; i < 40; i++) begin
      half_m = (m_per / 2 < 1) ? 1 : m_per / 2;
      if (m_clk == 1 && m_ph < half_m - 1) break;
      tick(1'b0);
    end
    tick(1'b1);
    chk("invert_forced_fall", clk_rec, 0);
    chk("invert_no_valid", bit_valid, 0);
    ticks(100);
    valid_gap(gap);
    chk("bit_valid_gap_after_invert", gap, 20);

    // invert coincident with a scheduled toggle: net no toggle
    for (int i = 0; i < 40; i++) begin
      half_m = (m_per / 2 < 1) ? 1 : m_per / 2;
      if (m_ph >= half_m - 1) break;
      tick(1'b0);
    end
    prev_clk = m_clk;
    tick(1'b1);
    chk("invert_coincident", clk_rec, prev_clk);
    ticks(60);

    // loss of signal: input held static after a transition
    for (int i = 0; i < 40 && bit_pos != 1; i++) tick(1'b0);
    run = 1'b0;
    ticks(150);
    chk("still_tracking_before_timeout", (state != 2'b00), 1);
    ticks(30);
    chk("timeout_state_idle", state, 0);
    chk("timeout_locked", locked, 0);
    chk("timeout_period_kept", (period == 20 || period == 21), 1);
    cnt_v = 0;
    for (int i = 0; i < 100; i++) begin tick(1'b0); if (bit_valid) cnt_v++; end
    chk("no_valid_after_timeout", cnt_v, 0);

    // restart, relock, then a 2-cycle glitch inside a bit
    run = 1'b1;
    ticks(760);
    chk("locked_before_glitch", locked, 1);
    for (int i = 0; i < 40 && bit_pos != 1; i++) tick(1'b0);
    glitch_arm = 1'b1;
    ticks(30);
    if (FILT) begin
      chk("glitch_period", (period == 20 || period == 21), 1);
      chk("glitch_locked", locked, 1);
    end else begin
      chk("glitch_period", period, 2);
      chk("glitch_locked", locked, 0);
    end
    ticks(200);

    // asynchronous reset mid-operation
    rst_n = 1'b0;
    #1;
    chk("async_reset_period", period, 801);
    chk("async_reset_state", state, 0);
    chk("async_reset_clk_rec", clk_rec, 0);
    @(negedge clk);
    bit_len = 3;
    ticks(5);
    chk("midop_reset_locked", locked, 0);
    chk("midop_reset_valid", bit_valid, 0);
    rst_n = 1'b1; lvl = 1'b0; bit_pos = 0; bit_len = 20;
    ticks(100);
    chk("post_reset_period", period, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
